// File: rtl/bitsel_writer.sv
// Single-bit writer into a declared-range vector [MSB:LSB] with signed indices,
// a one-deep write stage, out-of-range drop counting and a bit-serial clear sweep.
module bitsel_writer #(
   parameter int MSB  = 4,
   parameter int LSB  = 0,
   parameter int SELW = 5
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   input  logic signed [SELW-1:0] wr_sel,
   input  logic                   wr_bit,
   input  logic                   clr_start,
   output logic                   clr_busy,
   output logic                   clr_done,
   output logic [MSB:LSB]         data,
   output logic                   oor_err,
   output logic [7:0]             oor_count
);

   localparam bit ASC   = (MSB > LSB);
   localparam int WIDTH = ASC ? (MSB - LSB + 1) : (LSB - MSB + 1);
   localparam int LO    = ASC ? LSB : MSB;
   localparam int HI    = ASC ? MSB : LSB;
   localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic {
      ST_IDLE,
      ST_CLEAR
   } state_t;

   state_t                 r_state;
   logic [WIDTH-1:0]       r_data;
   logic                   r_stg_vld;
   logic signed [SELW-1:0] r_stg_sel;
   logic                   r_stg_bit;
   logic [CW-1:0]          r_clr_idx;
   logic                   r_clr_busy;
   logic                   r_clr_done;
   logic                   r_oor_err;
   logic [7:0]             r_oor_cnt;

   logic                   w_accept;
   logic                   w_in_range;
   logic                   w_hit;
   logic                   w_oor;
   int                     w_off;
   logic [WIDTH-1:0]       w_data_nxt;

   assign wr_ready  = rst_n && (r_state == ST_IDLE) && !clr_start;
   assign w_accept  = wr_valid && wr_ready;
   assign data      = r_data;
   assign clr_busy  = r_clr_busy;
   assign clr_done  = r_clr_done;
   assign oor_err   = r_oor_err;
   assign oor_count = r_oor_cnt;

   // An unknown index falls through to the drop branch, so it is counted rather than written.
   always_comb begin
      w_in_range = (int'(r_stg_sel) >= LO) && (int'(r_stg_sel) <= HI);
      w_off      = ASC ? (int'(r_stg_sel) - LSB) : (LSB - int'(r_stg_sel));
      w_hit      = 1'b0;
      w_oor      = 1'b0;
      if (r_stg_vld) begin
         if (w_in_range) w_hit = 1'b1;
         else            w_oor = 1'b1;
      end
   end

   // Sweep clear is applied after the staged write so it wins on a shared offset.
   always_comb begin
      w_data_nxt = r_data;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (w_hit && (w_off == int'(i)))
            w_data_nxt[i] = r_stg_bit;
         if ((r_state == ST_CLEAR) && (r_clr_idx == CW'(i)))
            w_data_nxt[i] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_data     <= '0;
         r_stg_vld  <= 1'b0;
         r_stg_sel  <= '0;
         r_stg_bit  <= 1'b0;
         r_clr_idx  <= '0;
         r_clr_busy <= 1'b0;
         r_clr_done <= 1'b0;
         r_oor_err  <= 1'b0;
         r_oor_cnt  <= '0;
      end else begin
         r_data    <= w_data_nxt;
         r_stg_vld <= w_accept;
         if (w_accept) begin
            r_stg_sel <= wr_sel;
            r_stg_bit <= wr_bit;
         end
         r_oor_err <= w_oor;
         if (w_oor && (r_oor_cnt != '1))
            r_oor_cnt <= r_oor_cnt + 8'd1;

         r_clr_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (clr_start) begin
                  r_state    <= ST_CLEAR;
                  r_clr_busy <= 1'b1;
                  r_clr_idx  <= '0;
               end
            end
            ST_CLEAR: begin
               if (r_clr_idx == CW'(WIDTH - 1)) begin
                  r_state    <= ST_IDLE;
                  r_clr_busy <= 1'b0;
                  r_clr_done <= 1'b1;
               end else begin
                  r_clr_idx <= r_clr_idx + 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bitsel_writer.sv
// Bench for bitsel_writer: seven range configurations side by side, directed scenarios
// followed by a random run against a declared-index reference model.
module tb_bitsel_writer;

   localparam int N = 7;
   localparam int PM [N] = '{4,  4, 0, -7, 6, 3, -1};
   localparam int PL [N] = '{0, -2, 6, -2, 0, 3, -5};

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic signed [4:0] wr_sel = '0;
   logic              wr_bit = 1'b0;
   logic              wv   [N];
   logic              cs   [N];
   logic              rdy  [N];
   logic              busy [N];
   logic              done [N];
   logic              err  [N];
   logic [7:0]        cnt  [N];
   logic [31:0]       dout [N];

   int n_cmp = 0;
   int n_err = 0;

   bit mdl [N][32];

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      logic [PM[g]:PL[g]] w_data;
      bitsel_writer #(.MSB(PM[g]), .LSB(PL[g]), .SELW(5)) u_dut (
         .clk(clk), .rst_n(rst_n),
         .wr_valid(wv[g]), .wr_ready(rdy[g]), .wr_sel(wr_sel), .wr_bit(wr_bit),
         .clr_start(cs[g]), .clr_busy(busy[g]), .clr_done(done[g]),
         .data(w_data), .oor_err(err[g]), .oor_count(cnt[g])
      );
      assign dout[g] = 32'(w_data);
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      for (int k = 0; k < N; k++) begin
         wv[k] = 1'b0;
         cs[k] = 1'b0;
      end
   endtask

   function automatic logic [31:0] exp_data(int k);
      logic [31:0] v;
      int w, idx;
      v = '0;
      w = (PM[k] > PL[k]) ? PM[k] - PL[k] + 1 : PL[k] - PM[k] + 1;
      for (int p = 0; p < w; p++) begin
         idx  = (PM[k] > PL[k]) ? PL[k] + p : PL[k] - p;
         v[p] = mdl[k][idx + 16];
      end
      return v;
   endfunction

   function automatic bit in_rng(int k, int s);
      int lo, hi;
      lo = (PM[k] < PL[k]) ? PM[k] : PL[k];
      hi = (PM[k] < PL[k]) ? PL[k] : PM[k];
      return (s >= lo) && (s <= hi);
   endfunction

   task automatic check_all_zero(string tag);
      for (int k = 0; k < N; k++) begin
         n_cmp++;
         if ({rdy[k], busy[k], done[k], err[k], cnt[k], dout[k]} !== '0) begin
            n_err++;
            $display("FAIL %s k=%0d got rdy=%b busy=%b done=%b err=%b cnt=%0d data=%h exp all 0",
                     tag, k, rdy[k], busy[k], done[k], err[k], cnt[k], dout[k]);
         end
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      repeat (3) tick();
      check_all_zero("reset_state");
      rst_n = 1'b1;
      #1;
      for (int k = 0; k < N; k++) begin
         n_cmp++;
         if (rdy[k] !== 1'b1) begin
            n_err++;
            $display("FAIL ready_after_reset k=%0d got %b exp 1", k, rdy[k]);
         end
      end
   endtask

   task automatic test_asc_negative();
      wv[1] = 1'b1; wr_sel = -5'sd2; wr_bit = 1'b1;
      tick();
      wv[1] = 1'b0;
      n_cmp++;
      if (dout[1] !== 32'h0) begin
         n_err++;
         $display("FAIL asc_neg_latency got %h exp 0", dout[1]);
      end
      tick();
      n_cmp++;
      if (dout[1] !== 32'h1) begin
         n_err++;
         $display("FAIL asc_neg_data got %h exp 1", dout[1]);
      end
      n_cmp++;
      if (err[1] !== 1'b0) begin
         n_err++;
         $display("FAIL asc_neg_oor got %b exp 0", err[1]);
      end
   endtask

   task automatic test_back_to_back();
      wv[2] = 1'b1; wr_sel = 5'sd0; wr_bit = 1'b1;
      tick();
      n_cmp++;
      if (rdy[2] !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_ready got %b exp 1", rdy[2]);
      end
      wr_sel = 5'sd6;
      tick();
      wv[2] = 1'b0;
      tick();
      n_cmp++;
      if (dout[2] !== 32'h41) begin
         n_err++;
         $display("FAIL b2b_data got %h exp 41", dout[2]);
      end
   endtask

   task automatic test_oor();
      logic signed [4:0] sels [3];
      int pulses;
      sels = '{-5'sd8, -5'sd1, 5'sd5};
      pulses = 0;
      wr_bit = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wv[3] = 1'b1; wr_sel = sels[i];
         tick();
         pulses += int'(err[3]);
      end
      wv[3] = 1'b0;
      repeat (3) begin
         tick();
         pulses += int'(err[3]);
      end
      n_cmp++;
      if (pulses != 3) begin
         n_err++;
         $display("FAIL oor_pulses got %0d exp 3", pulses);
      end
      n_cmp++;
      if (cnt[3] !== 8'd3) begin
         n_err++;
         $display("FAIL oor_count got %0d exp 3", cnt[3]);
      end
      n_cmp++;
      if (dout[3] !== 32'h0) begin
         n_err++;
         $display("FAIL oor_data got %h exp 0", dout[3]);
      end
   endtask

   task automatic test_clear();
      int bc, dc;
      wr_bit = 1'b1;
      for (int i = 0; i < 7; i++) begin
         wv[4] = 1'b1; wr_sel = 5'(i);
         tick();
      end
      wv[4] = 1'b0;
      tick();
      n_cmp++;
      if (dout[4] !== 32'h7f) begin
         n_err++;
         $display("FAIL clear_fill got %h exp 7f", dout[4]);
      end
      cs[4] = 1'b1; wv[4] = 1'b1; wr_sel = 5'sd3;
      #1;
      n_cmp++;
      if (rdy[4] !== 1'b0) begin
         n_err++;
         $display("FAIL clear_blocks_write got ready=%b exp 0", rdy[4]);
      end
      tick();
      cs[4] = 1'b0; wv[4] = 1'b0;
      bc = int'(busy[4]);
      dc = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         bc += int'(busy[4]);
         dc += int'(done[4]);
         if (busy[4] === 1'b1) begin
            n_cmp++;
            if (rdy[4] !== 1'b0) begin
               n_err++;
               $display("FAIL clear_ready_busy got %b exp 0", rdy[4]);
            end
         end
      end
      n_cmp++;
      if (bc != 7) begin
         n_err++;
         $display("FAIL clear_busy_cycles got %0d exp 7", bc);
      end
      n_cmp++;
      if (dc != 1) begin
         n_err++;
         $display("FAIL clear_done_pulses got %0d exp 1", dc);
      end
      n_cmp++;
      if (dout[4] !== 32'h0) begin
         n_err++;
         $display("FAIL clear_data got %h exp 0", dout[4]);
      end
   endtask

   task automatic test_saturate();
      wv[0] = 1'b1; wr_sel = 5'sd10; wr_bit = 1'b1;
      repeat (300) tick();
      wv[0] = 1'b0;
      repeat (2) tick();
      n_cmp++;
      if (cnt[0] !== 8'd255) begin
         n_err++;
         $display("FAIL sat_count got %0d exp 255", cnt[0]);
      end
      n_cmp++;
      if (dout[0] !== 32'h0) begin
         n_err++;
         $display("FAIL sat_data got %h exp 0", dout[0]);
      end
   endtask

   task automatic test_reset_mid_clear();
      int dc;
      wv[6] = 1'b1; wr_sel = -5'sd3; wr_bit = 1'b1;
      tick();
      wv[6] = 1'b0;
      tick();
      cs[6] = 1'b1;
      tick();
      cs[6] = 1'b0;
      tick();
      n_cmp++;
      if (busy[6] !== 1'b1) begin
         n_err++;
         $display("FAIL midclr_busy got %b exp 1", busy[6]);
      end
      rst_n = 1'b0;
      #1;
      check_all_zero("midclr_reset");
      tick();
      rst_n = 1'b1;
      dc = 0;
      repeat (10) begin
         tick();
         dc += int'(done[6]) + int'(busy[6]);
      end
      n_cmp++;
      if (dc != 0) begin
         n_err++;
         $display("FAIL midclr_no_done got %0d busy/done samples exp 0", dc);
      end
   endtask

   task automatic test_random();
      bit stg_v [N];
      int stg_s [N];
      bit stg_b [N];
      bit acc   [N];
      bit exp_e [N];
      int exp_c [N];
      int s;
      bit b;
      for (int k = 0; k < N; k++) begin
         stg_v[k] = 1'b0; stg_s[k] = 0; stg_b[k] = 1'b0; exp_c[k] = 0;
         for (int j = 0; j < 32; j++) mdl[k][j] = 1'b0;
      end
      for (int c = 0; c < 10000; c++) begin
         for (int k = 0; k < N; k++) begin
            wv[k]  = 1'($urandom_range(0, 1));
            acc[k] = wv[k];
         end
         if ($urandom_range(0, 1) == 1) wr_sel = 5'(int'($urandom_range(0, 15)) - 8);
         else                           wr_sel = 5'($urandom_range(0, 31));
         wr_bit = 1'($urandom_range(0, 1));
         s = int'(wr_sel);
         b = wr_bit;
         tick();
         for (int k = 0; k < N; k++) begin
            exp_e[k] = 1'b0;
            if (stg_v[k]) begin
               if (in_rng(k, stg_s[k])) mdl[k][stg_s[k] + 16] = stg_b[k];
               else begin
                  exp_e[k] = 1'b1;
                  if (exp_c[k] < 255) exp_c[k]++;
               end
            end
            stg_v[k] = acc[k]; stg_s[k] = s; stg_b[k] = b;
            n_cmp++;
            if (dout[k] !== exp_data(k)) begin
               n_err++;
               $display("FAIL rand_data c=%0d k=%0d got %h exp %h", c, k, dout[k], exp_data(k));
            end
            n_cmp++;
            if (err[k] !== exp_e[k] || cnt[k] !== 8'(exp_c[k])) begin
               n_err++;
               $display("FAIL rand_oor c=%0d k=%0d got err=%b cnt=%0d exp err=%b cnt=%0d",
                        c, k, err[k], cnt[k], exp_e[k], exp_c[k]);
            end
            n_cmp++;
            if (rdy[k] !== 1'b1) begin
               n_err++;
               $display("FAIL rand_ready c=%0d k=%0d got %b exp 1", c, k, rdy[k]);
            end
         end
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_asc_negative();
      test_back_to_back();
      test_oor();
      test_clear();
      test_saturate();
      test_reset_mid_clear();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
